// File: rtl/eth_pkg.sv
// eth_pkg: constants shared by the MAC and its TX-side arbiter
package eth_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam int ETH_MAX_FRAME_BYTES = 1514;
  localparam int ETH_BYTE_W = 8;
endpackage

// File: rtl/eth_rr_pick.sv
// eth_rr_pick: combinational round-robin picker searching upward from one past the last winner
module eth_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IW = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        last,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IW-1:0]        idx,
  output logic                 valid
);
  logic [IW-1:0] c;
  always_comb begin
    grant = '0;
    idx = '0;
    valid = 1'b0;
    c = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      c = IW'((int'(last) + k) % NUM_PORTS);
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx = c;
        grant[c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-granular round-robin mux of AXI-Stream sources onto the MAC TX byte stream
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME_BYTES,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS*ETH_BYTE_W-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]          s_axis_tlast,
  output logic [NUM_PORTS-1:0]          s_axis_tready,
  output logic [ETH_BYTE_W-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  input  logic [NUM_PORTS-1:0]          port_enable,
  output logic [NUM_PORTS-1:0]          grant,
  output logic                          busy,
  output logic [NUM_PORTS*CNT_W-1:0]    frame_count,
  output logic [CNT_W-1:0]              oversize_count
);
  localparam int IW = $clog2(NUM_PORTS);
  localparam int BW = $clog2(MAX_FRAME_BYTES + 1);

  logic [1:0]            state, state_next;
  logic [IW-1:0]         g, last_grant, pick_idx;
  logic [NUM_PORTS-1:0]  pick_grant;
  logic                  pick_valid;
  logic [BW-1:0]         byte_cnt;
  logic [ETH_BYTE_W-1:0] sel_data;
  logic                  sel_valid, sel_last, at_max, beat, frame_end;

  eth_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req   (s_axis_tvalid & port_enable),
    .last  (last_grant),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    sel_data = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      sel_data = grant[p] ? s_axis_tdata[p*ETH_BYTE_W +: ETH_BYTE_W] : sel_data;
  end

  assign sel_valid = s_axis_tvalid[g];
  assign sel_last  = s_axis_tlast[g];
  assign at_max    = byte_cnt == BW'(MAX_FRAME_BYTES - 1);
  assign beat      = m_axis_tvalid && m_axis_tready;
  assign frame_end = (beat && sel_last) || (state == ST_DRAIN && sel_valid && sel_last);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_next;

  always_comb
    state_next = (state == ST_IDLE) ? (pick_valid ? ST_PASS : ST_IDLE)
               : (state == ST_PASS) ? (beat && sel_last ? ST_IDLE : beat && at_max ? ST_DRAIN : ST_PASS)
               : (sel_valid && sel_last) ? ST_IDLE : ST_DRAIN;

  always_comb begin
    m_axis_tdata  = (state == ST_PASS) ? sel_data : '0;
    m_axis_tvalid = (state == ST_PASS) && sel_valid;
    m_axis_tlast  = (state == ST_PASS) && (sel_last || at_max);
    s_axis_tready = (state == ST_PASS) ? (grant & {NUM_PORTS{m_axis_tready}})
                  : (state == ST_DRAIN) ? grant : '0;
    busy          = state != ST_IDLE;
  end

  // A truncated frame counts as completed at its forced tlast; the drain only discards
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grant          <= '0;
      g              <= '0;
      last_grant     <= IW'(NUM_PORTS - 1);
      byte_cnt       <= '0;
      frame_count    <= '0;
      oversize_count <= '0;
    end else begin
      if (state == ST_IDLE && pick_valid) begin
        grant <= pick_grant;
        g     <= pick_idx;
      end
      if (beat) byte_cnt <= byte_cnt + 1'b1;
      if (beat && (sel_last || at_max))
        for (int p = 0; p < NUM_PORTS; p++)
          if (grant[p]) frame_count[p*CNT_W +: CNT_W] <= frame_count[p*CNT_W +: CNT_W] + 1'b1;
      if (beat && at_max && !sel_last) oversize_count <= oversize_count + 1'b1;
      if (frame_end) begin
        grant      <= '0;
        last_grant <= g;
        byte_cnt   <= '0;
      end
    end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed scoreboard bench for the TX arbiter
module tb_eth_tx_arbiter;
  localparam int N = 4;
  localparam int CW = 16;
  localparam int MAXB = 1514;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*8-1:0] s_axis_tdata;
  logic [N-1:0] s_axis_tvalid, s_axis_tlast, s_axis_tready, port_enable, grant;
  logic [7:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready, busy;
  logic [N*CW-1:0] frame_count;
  logic [CW-1:0] oversize_count;

  eth_tx_arbiter #(.NUM_PORTS(N), .MAX_FRAME_BYTES(MAXB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .port_enable(port_enable), .grant(grant), .busy(busy),
    .frame_count(frame_count), .oversize_count(oversize_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] port;
    logic       last;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic [8:0] src_mem [N][4096];
  int src_wr[N], src_rd[N], fc_exp[N];
  int ovs_exp, checks, passed, out_beats;
  bit rand_valid, rand_ready, gap_chk;
  logic [N-1:0] fire_prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic stim(input int p, input int len, output int start);
    start = src_wr[p];
    for (int i = 0; i < len; i++) begin
      src_mem[p][src_wr[p]] = {i == len - 1, 8'($urandom)};
      src_wr[p]++;
    end
  endtask

  // Expected output: bytes beyond the limit are dropped, the limit byte carries tlast
  task automatic expect_frame(input int p, input int start, input int len);
    exp_t e;
    for (int i = 0; i < len && i < MAXB; i++) begin
      e.port = 2'(p);
      e.data = src_mem[p][start+i][7:0];
      e.last = (i == len - 1) || (i == MAXB - 1);
      exp_q.push_back(e);
    end
    fc_exp[p]++;
    if (len > MAXB) ovs_exp++;
  endtask

  task automatic send(input int p, input int len);
    int s;
    stim(p, len, s);
    expect_frame(p, s, len);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    do begin @(negedge clk); #2; n++; end
    while ((exp_q.size() != 0 || busy) && n < budget);
    chk(tag, {exp_q.size() == 0, busy}, 64'b10);
  endtask

  task automatic wait_grant(input string tag, input logic [N-1:0] want, input int budget);
    int n = 0;
    while (grant !== want && n < budget) begin @(negedge clk); #2; n++; end
    chk(tag, grant, want);
  endtask

  task automatic wait_beats(input string tag, input int target, input int budget);
    int n = 0;
    while (out_beats < target && n < budget) begin @(negedge clk); #2; n++; end
    chk(tag, out_beats >= target, 1);
  endtask

  task automatic check_counters(input string tag);
    for (int p = 0; p < N; p++)
      chk($sformatf("%s_frame_count%0d", tag, p), frame_count[p*CW +: CW], fc_exp[p]);
    chk({tag, "_oversize"}, oversize_count, ovs_exp);
  endtask

  task automatic flush();
    exp_q.delete();
    for (int p = 0; p < N; p++) begin
      src_rd[p] = src_wr[p];
      fc_exp[p] = 0;
    end
    ovs_exp = 0;
    fire_prev = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    flush();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // Source drivers and output monitor: drive after negedge, sample what the next posedge sees
  initial begin
    bit have;
    logic [12:0] ew;
    exp_t e;
    s_axis_tvalid = '0;
    s_axis_tlast = '0;
    s_axis_tdata = '0;
    m_axis_tready = 1'b1;
    fire_prev = '0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < N; p++)
        if (fire_prev[p] && src_rd[p] < src_wr[p]) src_rd[p]++;
      for (int p = 0; p < N; p++) begin
        have = src_rd[p] < src_wr[p];
        s_axis_tvalid[p] = have && (!rand_valid || $urandom_range(0, 1) == 1);
        {s_axis_tlast[p], s_axis_tdata[p*8 +: 8]} = have ? src_mem[p][src_rd[p]] : 9'h0;
      end
      m_axis_tready = !rand_ready || ($urandom_range(0, 2) != 0);
      #1;
      fire_prev = s_axis_tvalid & s_axis_tready;
      if (gap_chk) chk("frame_gap", m_axis_tvalid, 0);
      gap_chk = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        out_beats++;
        ew = '0;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          ew = {4'b0001 << e.port, e.last, e.data};
        end
        chk("out_beat", {grant, m_axis_tlast, m_axis_tdata}, ew);
        gap_chk = m_axis_tlast;
      end
    end
  end

  initial begin
    int b0, s2;
    port_enable = '1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    check_counters("rst");
    rst = 1'b0;

    // single 64-byte frame from port 1, one cycle of arbitration latency
    @(negedge clk); #2;
    b0 = out_beats;
    send(1, 64);
    @(negedge clk); #2;
    chk("t1_arb_cycle_idle", {busy, grant}, 0);
    @(negedge clk); #2;
    chk("t1_grant", grant, 4'b0010);
    wait_done("t1_done", 300);
    chk("t1_beats", out_beats - b0, 64);
    chk("t1_grant_after", grant, 0);
    check_counters("t1");

    // ports 0 and 2 alternate frame by frame
    do_reset();
    send(0, 10); send(2, 10); send(0, 10); send(2, 10);
    wait_done("t2_done", 300);
    check_counters("t2");

    // disabled port 2 is ignored; re-enabling mid-frame does not preempt port 3
    @(negedge clk); #2;
    port_enable = 4'b1011;
    stim(2, 8, s2);
    repeat (6) @(negedge clk);
    #2;
    chk("t3_disabled_idle", {busy, grant}, 0);
    send(3, 20);
    wait_grant("t3_grant3", 4'b1000, 50);
    repeat (3) @(negedge clk);
    port_enable = 4'b1111;
    repeat (2) @(negedge clk);
    #2;
    chk("t3_no_preempt", grant, 4'b1000);
    expect_frame(2, s2, 8);
    wait_done("t3_done", 300);
    check_counters("t3");

    // oversize frame is truncated and drained; the following frame is intact
    b0 = out_beats;
    send(0, 1600);
    send(1, 5);
    wait_done("t4_done", 4000);
    chk("t4_beats", out_beats - b0, MAXB + 5);
    chk("t4_src0_drained", src_rd[0], src_wr[0]);
    check_counters("t4");

    // random backpressure and source stalls
    rand_valid = 1'b1;
    rand_ready = 1'b1;
    b0 = out_beats;
    send(1, 100);
    wait_done("t5_done", 3000);
    rand_valid = 1'b0;
    rand_ready = 1'b0;
    chk("t5_beats", out_beats - b0, 100);
    check_counters("t5");

    // asynchronous reset mid-frame, then port 0 wins first
    @(negedge clk); #2;
    b0 = out_beats;
    send(3, 60);
    wait_beats("t6_reach30", b0 + 30, 200);
    rst = 1'b1;
    #1;
    chk("t6_async_tready", s_axis_tready, 0);
    chk("t6_async_m_tvalid", m_axis_tvalid, 0);
    chk("t6_async_grant", grant, 0);
    chk("t6_async_busy", busy, 0);
    flush();
    repeat (2) @(negedge clk);
    #2;
    check_counters("t6_rst");
    rst = 1'b0;
    send(0, 4);
    send(3, 4);
    wait_done("t6_done", 200);
    check_counters("t6");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
